// File: rtl/pipeline_pkg.sv
// Shared decode definitions for pipeline stage 1: state encoding, length
// constants and the opcode length rule.
package pipeline_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        IMM_LO = 2'd1,
        IMM_HI = 2'd2
    } state_e;

    localparam logic [1:0] LEN1   = 2'd1;
    localparam logic [1:0] LEN2   = 2'd2;
    localparam logic [1:0] LEN3   = 2'd3;
    localparam logic [7:0] NOP_OP = 8'h00;

    // Top two opcode bits select total instruction length; NOP (0x00) is 1 byte.
    function automatic logic [1:0] op_len(input logic [7:0] op);
        logic [1:0] len;
        case (op[7:6])
            2'b11:   len = LEN3;
            2'b10:   len = LEN2;
            default: len = LEN1;
        endcase
        return len;
    endfunction

endpackage

// File: rtl/pipeline_stage1_decode.sv
// Pipeline stage 1: assembles opcode plus 0..2 little-endian immediate bytes
// from the fetch byte stream and holds each complete instruction for stage 2.
module pipeline_stage1_decode
    import pipeline_pkg::*;
#(
    parameter int IMM_W = 16
) (
    input  logic             ClockIn,
    input  logic             ResetIn_n,
    input  logic [7:0]       PipeIn,
    input  logic             PipeValid,
    input  logic             Flush,
    input  logic             Stall,
    output logic [7:0]       InstrOut,
    output logic [IMM_W-1:0] ImmOut,
    output logic [1:0]       InstrLen,
    output logic             InstrValid,
    output logic             FetchSurpressOut
);

    // Handshake: a held instruction (InstrValid=1) transfers to stage 2 on any
    // cycle with Stall=0. A fetch byte is consumed only when PipeValid=1, no
    // held instruction is stalled (FetchSurpressOut=0) and Flush=0; otherwise
    // the fetch stage replays the same byte next cycle.
    state_e           state_q, state_d;
    logic [7:0]       stage_op_q, stage_op_d;
    logic [7:0]       stage_lo_q, stage_lo_d;
    logic [7:0]       instr_q, instr_d;
    logic [IMM_W-1:0] imm_q, imm_d;
    logic [1:0]       len_q, len_d;
    logic             valid_q, valid_d;

    logic             fetch_suppress;
    logic             accept;
    logic             xfer;
    logic             load;

    always_comb begin
        state_d    = state_q;
        stage_op_d = stage_op_q;
        stage_lo_d = stage_lo_q;
        instr_d    = instr_q;
        imm_d      = imm_q;
        len_d      = len_q;
        valid_d    = valid_q;
        load       = 1'b0;

        fetch_suppress = valid_q & Stall & ~Flush;
        accept         = PipeValid & ~fetch_suppress & ~Flush;
        xfer           = valid_q & ~Stall;

        if (Flush) begin
            state_d    = IDLE;
            stage_op_d = NOP_OP;
            stage_lo_d = 8'h00;
            valid_d    = 1'b0;
        end else begin
            if (accept) begin
                case (state_q)
                    IDLE: begin
                        if (op_len(PipeIn) == LEN1) begin
                            load    = 1'b1;
                            instr_d = PipeIn;
                            imm_d   = '0;
                            len_d   = LEN1;
                        end else begin
                            stage_op_d = PipeIn;
                            state_d    = IMM_LO;
                        end
                    end
                    IMM_LO: begin
                        stage_lo_d = PipeIn;
                        if (op_len(stage_op_q) == LEN2) begin
                            load    = 1'b1;
                            instr_d = stage_op_q;
                            imm_d   = IMM_W'({8'h00, PipeIn});
                            len_d   = LEN2;
                            state_d = IDLE;
                        end else begin
                            state_d = IMM_HI;
                        end
                    end
                    IMM_HI: begin
                        load    = 1'b1;
                        instr_d = stage_op_q;
                        imm_d   = IMM_W'({PipeIn, stage_lo_q});
                        len_d   = LEN3;
                        state_d = IDLE;
                    end
                    default: state_d = IDLE;
                endcase
            end
            // Load and transfer in the same cycle keep valid high: no bubble.
            if (load) begin
                valid_d = 1'b1;
            end else if (xfer) begin
                valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge ClockIn or negedge ResetIn_n) begin
        if (!ResetIn_n) begin
            state_q    <= IDLE;
            stage_op_q <= NOP_OP;
            stage_lo_q <= 8'h00;
            instr_q    <= NOP_OP;
            imm_q      <= '0;
            len_q      <= 2'd0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            stage_op_q <= stage_op_d;
            stage_lo_q <= stage_lo_d;
            instr_q    <= instr_d;
            imm_q      <= imm_d;
            len_q      <= len_d;
            valid_q    <= valid_d;
        end
    end

    assign InstrOut         = instr_q;
    assign ImmOut           = imm_q;
    assign InstrLen         = len_q;
    assign InstrValid       = valid_q;
    assign FetchSurpressOut = valid_q & Stall & ~Flush;

endmodule

// File: tb/tb_pipeline_stage1_decode.sv
// Directed bench for pipeline_stage1_decode: a byte-queue instruction model
// checked every cycle, plus literal expectations at key points.
module tb_pipeline_stage1_decode;

    logic        ClockIn = 1'b0;
    logic        ResetIn_n = 1'b0;
    logic [7:0]  PipeIn = 8'h00;
    logic        PipeValid = 1'b0;
    logic        Flush = 1'b0;
    logic        Stall = 1'b0;
    logic [7:0]  InstrOut;
    logic [15:0] ImmOut;
    logic [1:0]  InstrLen;
    logic        InstrValid;
    logic        FetchSurpressOut;

    int n_cmp = 0;
    int n_fail = 0;

    pipeline_stage1_decode #(.IMM_W(16)) dut (
        .ClockIn          (ClockIn),
        .ResetIn_n        (ResetIn_n),
        .PipeIn           (PipeIn),
        .PipeValid        (PipeValid),
        .Flush            (Flush),
        .Stall            (Stall),
        .InstrOut         (InstrOut),
        .ImmOut           (ImmOut),
        .InstrLen         (InstrLen),
        .InstrValid       (InstrValid),
        .FetchSurpressOut (FetchSurpressOut)
    );

    // ---------------- clock ----------------
    always #5 ClockIn = ~ClockIn;

    // ---------------- checker ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Accepted bytes collect in a queue until the opcode's length is reached,
    // then the whole instruction becomes the expected held instruction.
    logic [7:0]  part_q[$];
    logic        m_valid = 1'b0;
    logic [7:0]  m_instr = 8'h00;
    logic [15:0] m_imm = 16'h0000;
    logic [1:0]  m_len = 2'd0;

    function automatic int len_of(input logic [7:0] op);
        if (op >= 8'hC0) return 3;
        if (op >= 8'h80) return 2;
        return 1;
    endfunction

    always @(posedge ClockIn or negedge ResetIn_n) begin
        if (!ResetIn_n) begin
            part_q.delete();
            m_valid = 1'b0;
            m_instr = 8'h00;
            m_imm   = 16'h0000;
            m_len   = 2'd0;
        end else begin
            logic held_stalled;
            logic loaded;
            held_stalled = m_valid && Stall;
            loaded = 1'b0;
            if (Flush) begin
                part_q.delete();
                m_valid = 1'b0;
            end else begin
                if (PipeValid && !held_stalled) begin
                    part_q.push_back(PipeIn);
                    if (part_q.size() == len_of(part_q[0])) begin
                        m_instr = part_q[0];
                        m_imm   = 16'h0000;
                        if (part_q.size() > 1) m_imm = m_imm + 16'(part_q[1]);
                        if (part_q.size() > 2) m_imm = m_imm + 16'(part_q[2]) * 16'd256;
                        m_len   = 2'(part_q.size());
                        m_valid = 1'b1;
                        loaded  = 1'b1;
                        part_q.delete();
                    end
                end
                if (!loaded && m_valid && !Stall) m_valid = 1'b0;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge ClockIn) begin
        check("cyc_valid", 32'(InstrValid), 32'(m_valid));
        check("cyc_suppress", 32'(FetchSurpressOut), 32'(m_valid && Stall && !Flush));
        if (m_valid || !ResetIn_n) begin
            check("cyc_instr", 32'(InstrOut), 32'(m_instr));
            check("cyc_imm", 32'(ImmOut), 32'(m_imm));
            check("cyc_len", 32'(InstrLen), 32'(m_len));
        end
    end

    // ---------------- driver ----------------
    task automatic drive(input logic pv, input logic [7:0] b, input logic st, input logic fl);
        PipeValid = pv;
        PipeIn    = b;
        Stall     = st;
        Flush     = fl;
        @(posedge ClockIn);
        #1;
    endtask

    task automatic expect_instr(input string name, input logic [7:0] op,
                                input logic [15:0] imm, input logic [1:0] len);
        check({name, "_valid"}, 32'(InstrValid), 32'd1);
        check({name, "_instr"}, 32'(InstrOut), 32'(op));
        check({name, "_imm"}, 32'(ImmOut), 32'(imm));
        check({name, "_len"}, 32'(InstrLen), 32'(len));
    endtask

    task automatic expect_reset_outputs(input string name);
        check({name, "_instr"}, 32'(InstrOut), 32'h00);
        check({name, "_imm"}, 32'(ImmOut), 32'h0000);
        check({name, "_len"}, 32'(InstrLen), 32'd0);
        check({name, "_valid"}, 32'(InstrValid), 32'd0);
        check({name, "_suppress"}, 32'(FetchSurpressOut), 32'd0);
    endtask

    task automatic release_reset();
        @(negedge ClockIn);
        ResetIn_n = 1'b1;
        drive(1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        #12;
        expect_reset_outputs("reset");
        release_reset();

        // back-to-back 1-byte instructions
        drive(1'b1, 8'h01, 1'b0, 1'b0);
        expect_instr("b2b_01", 8'h01, 16'h0000, 2'd1);
        drive(1'b1, 8'h02, 1'b0, 1'b0);
        expect_instr("b2b_02", 8'h02, 16'h0000, 2'd1);
        drive(1'b1, 8'h03, 1'b0, 1'b0);
        expect_instr("b2b_03", 8'h03, 16'h0000, 2'd1);

        // 3-byte then 2-byte instruction
        drive(1'b1, 8'hC5, 1'b0, 1'b0);
        check("op3_mid_valid", 32'(InstrValid), 32'd0);
        drive(1'b1, 8'h34, 1'b0, 1'b0);
        check("op3_mid2_valid", 32'(InstrValid), 32'd0);
        drive(1'b1, 8'h12, 1'b0, 1'b0);
        expect_instr("op3", 8'hC5, 16'h1234, 2'd3);
        drive(1'b1, 8'h8A, 1'b0, 1'b0);
        check("op2_mid_valid", 32'(InstrValid), 32'd0);
        drive(1'b1, 8'h7F, 1'b0, 1'b0);
        expect_instr("op2", 8'h8A, 16'h007F, 2'd2);

        // stall holds 0x01 for three cycles while 0x02 waits at fetch
        drive(1'b1, 8'h01, 1'b0, 1'b0);
        expect_instr("stall_pre", 8'h01, 16'h0000, 2'd1);
        for (int i = 0; i < 3; i++) begin
            PipeValid = 1'b1;
            PipeIn    = 8'h02;
            Stall     = 1'b1;
            Flush     = 1'b0;
            #1;
            check("stall_suppress", 32'(FetchSurpressOut), 32'd1);
            @(posedge ClockIn);
            #1;
            expect_instr("stall_hold", 8'h01, 16'h0000, 2'd1);
        end
        drive(1'b1, 8'h02, 1'b0, 1'b0);
        expect_instr("stall_release", 8'h02, 16'h0000, 2'd1);
        drive(1'b1, 8'h03, 1'b0, 1'b0);
        expect_instr("stall_next", 8'h03, 16'h0000, 2'd1);

        // bubbles between operand bytes
        drive(1'b1, 8'hC5, 1'b0, 1'b0);
        drive(1'b1, 8'h34, 1'b0, 1'b0);
        drive(1'b0, 8'h99, 1'b0, 1'b0);
        check("bubble1_valid", 32'(InstrValid), 32'd0);
        drive(1'b0, 8'h99, 1'b0, 1'b0);
        check("bubble2_valid", 32'(InstrValid), 32'd0);
        drive(1'b1, 8'h12, 1'b0, 1'b0);
        expect_instr("bubble_op3", 8'hC5, 16'h1234, 2'd3);
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        check("bubble_drain", 32'(InstrValid), 32'd0);

        // flush mid-instruction, also while stalled with a held instruction
        drive(1'b1, 8'hC5, 1'b0, 1'b0);
        drive(1'b1, 8'h34, 1'b0, 1'b1);
        check("flush_valid", 32'(InstrValid), 32'd0);
        drive(1'b1, 8'h01, 1'b0, 1'b0);
        expect_instr("post_flush", 8'h01, 16'h0000, 2'd1);
        PipeValid = 1'b1;
        PipeIn    = 8'h05;
        Stall     = 1'b1;
        Flush     = 1'b1;
        #1;
        check("flush_over_stall_supp", 32'(FetchSurpressOut), 32'd0);
        @(posedge ClockIn);
        #1;
        check("flush_over_stall_valid", 32'(InstrValid), 32'd0);
        drive(1'b1, 8'h06, 1'b0, 1'b0);
        expect_instr("post_flush2", 8'h06, 16'h0000, 2'd1);

        // async reset while a held instruction is stalled
        PipeValid = 1'b1;
        PipeIn    = 8'h07;
        Stall     = 1'b1;
        Flush     = 1'b0;
        #2;
        check("pre_areset_supp", 32'(FetchSurpressOut), 32'd1);
        ResetIn_n = 1'b0;
        #1;
        expect_reset_outputs("areset_held");
        PipeValid = 1'b0;
        Stall     = 1'b0;
        release_reset();

        // async reset while waiting for the high immediate byte
        drive(1'b1, 8'hC5, 1'b0, 1'b0);
        drive(1'b1, 8'h34, 1'b0, 1'b0);
        #3;
        ResetIn_n = 1'b0;
        #1;
        expect_reset_outputs("areset_immhi");
        PipeValid = 1'b0;
        release_reset();
        drive(1'b1, 8'h12, 1'b0, 1'b0);
        expect_instr("post_areset", 8'h12, 16'h0000, 2'd1);
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        drive(1'b0, 8'h00, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
